// File: rtl/jc_phase_monitor.sv
// ---------------------------------------------------------------------------
// jc_phase_monitor
//
// Purpose
//   Watches the decoded one-hot outputs of a 10-phase Johnson counter, locks
//   onto the a0..a9 sequence, reports the active phase as a binary index and
//   counts completed decades (a9 -> a0 wraps) in BCD. Illegal patterns,
//   skipped phases and failure to find a0 in time drive the monitor into a
//   sticky FAULT state that only clr_i or rst can leave.
//
// Parameters
//   DIGITS        number of BCD digits in the decade count
//   SYNC_TIMEOUT  cycles allowed in SYNC without seeing a0 (>= 2)
//
// Ports
//   clk            rising-edge clock, shared with the Johnson counter
//   rst            asynchronous active-high reset
//   a0_i..a9_i     decoded one-hot phase inputs
//   clr_i          synchronous clear back to SYNC (count and flags zeroed)
//   locked_o       1 while tracking the sequence
//   phase_idx_o    binary index of the last accepted phase
//   bcd_o          decade count, digit 0 in [3:0]
//   decade_tick_o  one-cycle pulse when the count increments
//   ovf_o          sticky: count wrapped from all-9s to 0
//   err_o          1 while in FAULT
//   err_code_o     0 none, 1 not one-hot, 2 out of sequence, 3 sync timeout
//   state_o        current FSM state (0 SYNC, 1 TRACK, 2 FAULT) for debug
//
// Pipeline
//   Stage 1 registers {a9..a0} into ph_q; stage 2 is the FSM evaluating ph_q.
//   A pattern present before edge k shows up on the outputs after edge k+1.
// ---------------------------------------------------------------------------
module jc_phase_monitor #(
  parameter int DIGITS       = 3,
  parameter int SYNC_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a0_i,
  input  logic                  a1_i,
  input  logic                  a2_i,
  input  logic                  a3_i,
  input  logic                  a4_i,
  input  logic                  a5_i,
  input  logic                  a6_i,
  input  logic                  a7_i,
  input  logic                  a8_i,
  input  logic                  a9_i,
  input  logic                  clr_i,
  output logic                  locked_o,
  output logic [3:0]            phase_idx_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  decade_tick_o,
  output logic                  ovf_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [1:0]            state_o
);

  localparam int TW = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_ONEHOT  = 2'd1;
  localparam logic [1:0] CODE_SEQ     = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  // Stage 1: input register
  logic [9:0] ph_q;

  // Stage 2: FSM and registered outputs
  state_e                state_q,     state_d;
  logic [3:0]            phase_idx_q, phase_idx_d;
  logic [4*DIGITS-1:0]   bcd_q,       bcd_d;
  logic                  tick_q,      tick_d;
  logic                  ovf_q,       ovf_d;
  logic [1:0]            code_q,      code_d;
  logic [TW-1:0]         tmo_q,       tmo_d;
  logic                  locked_q,    locked_d;
  logic                  err_q,       err_d;

  // Decode of the registered pattern
  logic [3:0]            ones_c;
  logic [3:0]            idx_c;
  logic                  valid_c;
  logic [3:0]            next_idx_c;

  // Decimal increment of the decade count
  logic [4*DIGITS-1:0]   bcd_inc_c;
  logic                  bcd_wrap_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q <= '0;
    end else begin
      ph_q <= {a9_i, a8_i, a7_i, a6_i, a5_i, a4_i, a3_i, a2_i, a1_i, a0_i};
    end
  end

  // Population count plus position of the (last) set bit; idx_c is only
  // meaningful when exactly one bit is set.
  always_comb begin
    ones_c = 4'd0;
    idx_c  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (ph_q[i]) begin
        ones_c = ones_c + 4'd1;
        idx_c  = 4'(i);
      end
    end
    valid_c = (ones_c == 4'd1);
  end

  assign next_idx_c = (phase_idx_q == 4'd9) ? 4'd0 : phase_idx_q + 4'd1;

  // Ripple +1 through the digits; a digit at 9 rolls to 0 and passes the
  // carry on. A carry out of the top digit means the count wrapped.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    bcd_inc_c = '0;
    carry     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      digit = bcd_q[4*d +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          digit = 4'd0;
        end else begin
          digit = digit + 4'd1;
          carry = 1'b0;
        end
      end
      bcd_inc_c[4*d +: 4] = digit;
    end
    bcd_wrap_c = carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      phase_idx_q <= 4'd0;
      bcd_q       <= '0;
      tick_q      <= 1'b0;
      ovf_q       <= 1'b0;
      code_q      <= CODE_NONE;
      tmo_q       <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_idx_q <= phase_idx_d;
      bcd_q       <= bcd_d;
      tick_q      <= tick_d;
      ovf_q       <= ovf_d;
      code_q      <= code_d;
      tmo_q       <= tmo_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_idx_d = phase_idx_q;
    bcd_d       = bcd_q;
    tick_d      = 1'b0;
    ovf_d       = ovf_q;
    code_d      = code_q;
    tmo_d       = '0;

    case (state_q)
      ST_SYNC: begin
        // Anything other than a clean a0 is ignored while hunting for lock.
        if (valid_c && (idx_c == 4'd0)) begin
          state_d     = ST_TRACK;
          phase_idx_d = 4'd0;
        end else if (tmo_q == TW'(SYNC_TIMEOUT - 1)) begin
          // This edge would bring the counter to SYNC_TIMEOUT.
          state_d = ST_FAULT;
          code_d  = CODE_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_TRACK: begin
        if (!valid_c) begin
          state_d = ST_FAULT;
          code_d  = CODE_ONEHOT;
        end else if (idx_c == phase_idx_q) begin
          // Same phase again: the counter may be stalled, not an error.
          phase_idx_d = phase_idx_q;
        end else if (idx_c == next_idx_c) begin
          phase_idx_d = idx_c;
          if (phase_idx_q == 4'd9) begin
            bcd_d  = bcd_inc_c;
            tick_d = 1'b1;
            if (bcd_wrap_c) begin
              ovf_d = 1'b1;
            end
          end
        end else begin
          // phase_idx keeps the last accepted value for diagnosis.
          state_d = ST_FAULT;
          code_d  = CODE_SEQ;
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase

    // Clear overrides everything above, including a decade wrap on this edge.
    if (clr_i) begin
      state_d     = ST_SYNC;
      phase_idx_d = 4'd0;
      bcd_d       = '0;
      tick_d      = 1'b0;
      ovf_d       = 1'b0;
      code_d      = CODE_NONE;
      tmo_d       = '0;
    end
  end

  assign locked_d = (state_d == ST_TRACK);
  assign err_d    = (state_d == ST_FAULT);

  assign locked_o      = locked_q;
  assign phase_idx_o   = phase_idx_q;
  assign bcd_o         = bcd_q;
  assign decade_tick_o = tick_q;
  assign ovf_o         = ovf_q;
  assign err_o         = err_q;
  assign err_code_o    = code_q;
  assign state_o       = state_q;

endmodule
